// File: rtl/run_ctrl.sv
// Command-driven load/run controller: a host loads words into a circular buffer,
// then runs for a set number of cycles while the buffer drains to a downstream sink.
module run_ctrl #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [63:0]   cmd_arg,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [2:0]    state,
  output logic          done,
  output logic          error,
  output logic [63:0]   cycle_cnt,
  output logic [63:0]   run_left
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [63:0]   DEPTH_64 = 64'(DEPTH);
  localparam logic [2:0]    OP_LOAD  = 3'd1;
  localparam logic [2:0]    OP_RUN   = 3'd2;
  localparam logic [2:0]    OP_POLL  = 3'd3;
  localparam logic [2:0]    OP_CLEAR = 3'd4;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_POLL  = 3'd4,
    ST_STOP  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  state_t        r_state, w_state_nx;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr_nx, w_rd_ptr_nx, w_occ;
  logic [AW:0]   r_ld_left, w_ld_left_nx;
  logic [63:0]   r_cycle_cnt, r_run_left, w_run_left_nx;
  logic          r_done, r_error;
  logic [DW-1:0] r_out_data, w_out_data_nx;
  logic          w_empty, w_full, w_fire, w_push, w_pop, w_clear;
  logic          w_load_ok, w_run_ok;

  function automatic logic f_cmd_ready(input state_t s);
    case (s)
      ST_READY, ST_POLL, ST_STOP, ST_ERROR: f_cmd_ready = 1'b1;
      default:                              f_cmd_ready = 1'b0;
    endcase
  endfunction

  // Extra pointer MSB separates a full buffer from an empty one.
  assign w_occ     = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_occ == {(AW+1){1'b0}});
  assign w_full    = (w_occ == DEPTH_W);
  assign cmd_ready = f_cmd_ready(r_state);
  assign ld_ready  = (r_state == ST_LOAD) && !w_full;
  assign out_valid = (r_state == ST_RUN) && !w_empty;
  assign w_fire    = cmd_valid && cmd_ready;
  assign w_push    = ld_valid && ld_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_load_ok = (cmd_arg != 64'd0) && (cmd_arg <= (DEPTH_64 - 64'(w_occ)));
  assign w_run_ok  = (cmd_arg != 64'd0) && !w_empty;

  // Next-state and counter updates.
  always_comb begin
    w_state_nx     = r_state;
    w_ld_left_nx   = r_ld_left;
    w_run_left_nx  = r_run_left;
    w_clear        = 1'b0;
    case (r_state)
      ST_RESET: w_state_nx = ST_READY;
      ST_READY: begin
        if (w_fire) begin
          case (cmd_op)
            OP_LOAD: begin
              if (w_load_ok) begin
                w_state_nx   = ST_LOAD;
                w_ld_left_nx = cmd_arg[AW:0];
              end else begin
                w_state_nx = ST_ERROR;
              end
            end
            OP_RUN: begin
              if (w_run_ok) begin
                w_state_nx    = ST_RUN;
                w_run_left_nx = cmd_arg;
              end else begin
                w_state_nx = ST_ERROR;
              end
            end
            default: w_state_nx = ST_ERROR;
          endcase
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_LOAD: begin
        if (w_push) begin
          w_ld_left_nx = r_ld_left - (AW+1)'(1);
          if (r_ld_left == (AW+1)'(1)) begin
            w_state_nx = ST_READY;
          end else begin
            w_state_nx = ST_LOAD;
          end
        end else begin
          w_state_nx = ST_LOAD;
        end
      end
      ST_RUN: begin
        w_run_left_nx = r_run_left - 64'd1;
        if (r_run_left == 64'd1) begin
          w_state_nx = ST_POLL;
        end else begin
          w_state_nx = ST_RUN;
        end
      end
      ST_POLL: begin
        if (w_fire) begin
          w_state_nx = (cmd_op == OP_POLL) ? ST_STOP : ST_ERROR;
        end else begin
          w_state_nx = ST_POLL;
        end
      end
      ST_STOP: begin
        if (w_fire) begin
          case (cmd_op)
            OP_POLL:  w_state_nx = ST_STOP;
            OP_CLEAR: begin
              w_state_nx = ST_READY;
              w_clear    = 1'b1;
            end
            default:  w_state_nx = ST_ERROR;
          endcase
        end else begin
          w_state_nx = ST_STOP;
        end
      end
      ST_ERROR: begin
        if (w_fire && (cmd_op == OP_CLEAR)) begin
          w_state_nx = ST_READY;
          w_clear    = 1'b1;
        end else begin
          w_state_nx = ST_ERROR;
        end
      end
      default: w_state_nx = ST_ERROR;
    endcase
  end

  // Pointer updates and the head word to present on the following cycle.
  always_comb begin
    w_wr_ptr_nx   = w_clear ? {(AW+1){1'b0}} : (r_wr_ptr + (AW+1)'(w_push));
    w_rd_ptr_nx   = w_clear ? {(AW+1){1'b0}} : (r_rd_ptr + (AW+1)'(w_pop));
    w_out_data_nx = {DW{1'b0}};
    // Writes never coincide with RUN, so the array already holds the next head.
    if ((w_state_nx == ST_RUN) && (w_wr_ptr_nx != w_rd_ptr_nx)) begin
      w_out_data_nx = r_mem[w_rd_ptr_nx[AW-1:0]];
    end else begin
      w_out_data_nx = {DW{1'b0}};
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_wr_ptr    <= {(AW+1){1'b0}};
      r_rd_ptr    <= {(AW+1){1'b0}};
      r_ld_left   <= {(AW+1){1'b0}};
      r_cycle_cnt <= 64'd0;
      r_run_left  <= 64'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_out_data  <= {DW{1'b0}};
    end else begin
      r_state     <= w_state_nx;
      r_wr_ptr    <= w_wr_ptr_nx;
      r_rd_ptr    <= w_rd_ptr_nx;
      r_ld_left   <= w_ld_left_nx;
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      r_run_left  <= w_run_left_nx;
      r_done      <= (w_state_nx == ST_STOP);
      r_error     <= (w_state_nx == ST_ERROR);
      r_out_data  <= w_out_data_nx;
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= ld_data;
    end
  end

  assign state     = r_state;
  assign done      = r_done;
  assign error     = r_error;
  assign cycle_cnt = r_cycle_cnt;
  assign run_left  = r_run_left;
  assign out_data  = r_out_data;

endmodule
